// File: rtl/transmit_buffer.sv
// transmit_buffer: double-buffered 8N1 serial transmitter paced by a baud-rate enable tick.
module transmit_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    output logic       TxD,
    output logic       tbr
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] tx_buf, shifter, shifter_n;
    logic [2:0] bit_cnt, cnt_n;
    logic buf_full, load, wr, txd_n;

    assign databus = 8'bz;
    assign wr = iocs & ~iorw & (ioaddr == 2'b00);
    assign tbr = ~buf_full;

    always_comb begin
        state_n = state;
        shifter_n = shifter;
        cnt_n = bit_cnt;
        txd_n = TxD;
        load = 1'b0;
        if (enable)
            case (state)
                IDLE, STOP: begin
                    load = buf_full;
                    state_n = buf_full ? START : IDLE;
                    shifter_n = buf_full ? tx_buf : shifter;
                    txd_n = ~buf_full;
                end
                START: begin
                    txd_n = shifter[0];
                    shifter_n = shifter >> 1;
                    cnt_n = 3'd0;
                    state_n = DATA;
                end
                DATA: begin
                    // bit_cnt saturates at 7: that slot sends the stop bit instead of wrapping
                    txd_n = (bit_cnt == 3'd7) ? 1'b1 : shifter[0];
                    shifter_n = shifter >> 1;
                    cnt_n = (bit_cnt == 3'd7) ? bit_cnt : bit_cnt + 3'd1;
                    state_n = (bit_cnt == 3'd7) ? STOP : DATA;
                end
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            TxD <= 1'b1;
            buf_full <= 1'b0;
            tx_buf <= 8'h00;
            shifter <= 8'h00;
            bit_cnt <= 3'd0;
        end else begin
            state <= state_n;
            TxD <= txd_n;
            shifter <= shifter_n;
            bit_cnt <= cnt_n;
            // a load needs buf_full=1 and an accepted write needs buf_full=0, so they never collide
            if (load)
                buf_full <= 1'b0;
            else if (wr && !buf_full) begin
                buf_full <= 1'b1;
                tx_buf <= databus;
            end
        end
    end
endmodule

// File: tb/tb_transmit_buffer.sv
// tb_transmit_buffer: directed writes push expected frames; a monitor decodes TxD at each enable and checks them.
module tb_transmit_buffer;
    logic clk = 0, rst = 0, enable = 0, iocs = 0, iorw = 0, en_on = 0;
    logic [1:0] ioaddr = 0;
    logic [7:0] bus = 0;
    wire  [7:0] databus;
    logic TxD, tbr;
    int errs = 0, checks = 0;
    int ph = 15;
    typedef struct {logic [7:0] d; int gap;} exp_t;
    exp_t sb[$];
    exp_t e;
    int bitn = -1, gap = 1000, fgap = 0;
    logic [7:0] rx = 0;
    logic prev = 1;

    assign databus = bus;

    transmit_buffer dut (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .databus(databus), .TxD(TxD), .tbr(tbr)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // baud tick: one clk wide every 16 clocks while en_on; restarts immediately when re-enabled
    initial forever begin
        @(negedge clk);
        if (en_on) begin
            ph = (ph == 15) ? 0 : ph + 1;
            enable = (ph == 0);
        end else begin
            ph = 15;
            enable = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            bitn = -1;
            gap = 1000;
            prev = TxD;
        end else begin
            if (!enable)
                check("txd_hold", int'(TxD), int'(prev));
            else if (bitn < 0) begin
                if (TxD == 1'b0) begin
                    bitn = 0;
                    fgap = gap;
                end else
                    gap++;
            end else if (bitn < 8) begin
                rx[bitn] = TxD;
                bitn++;
            end else begin
                check("stop_bit", int'(TxD), 1);
                checks++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_frame: got %0h expected none at %0t", rx, $time);
                end else begin
                    e = sb.pop_front();
                    if (rx != e.d) begin
                        errs++;
                        $display("FAIL frame_data: got %0h expected %0h at %0t", rx, e.d, $time);
                    end
                    if (e.gap >= 0) check("frame_gap", fgap, e.gap);
                end
                bitn = -1;
                gap = 0;
            end
            prev = TxD;
        end
    end

    task automatic wr(input logic [7:0] d, input logic c = 1'b1, input logic rw = 1'b0,
                      input logic [1:0] a = 2'b00);
        @(negedge clk);
        iocs = c; iorw = rw; ioaddr = a; bus = d;
        @(negedge clk);
        iocs = 0; iorw = 0; ioaddr = 0;
    endtask

    task automatic wait_tbr(input string name);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (tbr) begin
                check(name, int'(TxD), 0);
                return;
            end
        end
        checks++; errs++;
        $display("FAIL %s: got tbr=0 expected tbr=1 within 64 clk", name);
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && bitn < 0) begin
                checks++;
                return;
            end
        end
        checks++; errs++;
        $display("FAIL frame_timeout: got %0d pending expected 0 within %0d clk", sb.size(), n);
    endtask

    initial begin
        bit seen;
        #3 rst = 1;
        #1 check("reset_txd_tbr", int'({TxD, tbr}), 3);
        repeat (2) @(negedge clk);
        rst = 0;
        en_on = 1;
        // single byte
        sb.push_back('{8'hA5, -1});
        wr(8'hA5);
        check("tbr_after_write", int'(tbr), 0);
        wait_tbr("load_a5");
        wait_idle(400);
        // back-to-back
        sb.push_back('{8'h55, -1});
        wr(8'h55);
        wait_tbr("load_55");
        sb.push_back('{8'h0F, 0});
        wr(8'h0F);
        wait_idle(600);
        // overrun
        sb.push_back('{8'h11, -1});
        wr(8'h11);
        wait_tbr("load_11");
        sb.push_back('{8'h22, 0});
        wr(8'h22);
        check("tbr_full_22", int'(tbr), 0);
        wr(8'h33);
        check("tbr_full_33", int'(tbr), 0);
        wait_idle(600);
        // address decode
        wr(8'hFF, 1'b1, 1'b1, 2'b00);
        check("decode_read", int'(tbr), 1);
        wr(8'hFF, 1'b1, 1'b0, 2'b01);
        check("decode_addr1", int'(tbr), 1);
        wr(8'hFF, 1'b0, 1'b0, 2'b00);
        check("decode_nocs", int'(tbr), 1);
        repeat (40) @(negedge clk);
        check("decode_idle", int'({TxD, tbr}), 3);
        // idle wait without enable
        en_on = 0;
        repeat (2) @(negedge clk);
        sb.push_back('{8'h80, -1});
        wr(8'h80);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check("idle_wait", int'({TxD, tbr}), 2);
        end
        en_on = 1;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (enable) begin
                check("first_start", int'({TxD, tbr}), 1);
                seen = 1;
            end
        end
        if (!seen) begin
            checks++; errs++;
            $display("FAIL first_start: got no enable expected one within 4 clk");
        end
        wait_idle(400);
        // reset mid-frame with a pending byte
        wr(8'hC3);
        wait_tbr("load_c3");
        wr(8'h5A);
        for (int i = 0; i < 200 && bitn < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("reached_data", int'(bitn >= 3), 1);
        @(negedge clk);
        rst = 1;
        #1 check("rst_async", int'({TxD, tbr}), 3);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (300) @(negedge clk);
        check("post_reset_idle", int'({TxD, tbr}), 3);
        sb.push_back('{8'h3C, -1});
        wr(8'h3C);
        wait_idle(400);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
